// File: rtl/alu_ops_pkg.sv
// alu_ops_pkg: opcodes, sequencer state encoding and carry-in helper shared by the serial ALU
package alu_ops_pkg;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

    function automatic logic cin_init(input logic [2:0] op);
        return op == OP_SUB || op == OP_SLT;
    endfunction
endpackage

// File: rtl/alu_serial_slice.sv
// alu_serial_slice: combinational 1-bit ALU slice
module alu_serial_slice
    import alu_ops_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] op,
    output logic       s,
    output logic       cout
);
    logic inv, bb;
    always_comb begin
        inv  = cin_init(op);
        bb   = b ^ inv;
        cout = (a & bb) | (a & cin) | (bb & cin);
        s    = op == OP_AND ? a & b :
               op == OP_OR  ? a | b :
               op == OP_NOR ? ~(a | b) :
               (op == OP_ADD || inv) ? a ^ bb ^ cin : 1'b0;
    end
endmodule

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial ALU sequencer driving one slice LSB-first with SLT fix-up pass
module alu_serial_ctrl
    import alu_ops_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [2:0]       op_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);
    localparam int IW = $clog2(WIDTH);

    state_t           state, state_n;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_sr, b_sr, r_sr, r_next;
    logic [2:0]       op_q;
    logic             carry, set_q, s, co, last, arith, ov;

    alu_serial_slice u_slice (.a(a_sr[0]), .b(b_sr[0]), .cin(carry), .op(op_q), .s(s), .cout(co));

    assign last    = idx == IW'(WIDTH - 1);
    assign arith   = op_q == OP_ADD || op_q == OP_SUB;
    assign ov      = carry ^ co;
    assign ready_o = state == IDLE;
    assign busy_o  = state != IDLE;
    assign done_o  = state == DONE;

    always_comb begin
        state_n = state;
        r_next  = r_sr;
        case (state)
            IDLE: state_n = start_i ? RUN : IDLE;
            RUN: begin
                r_next  = {s, r_sr[WIDTH-1:1]};
                state_n = !last ? RUN : op_q == OP_SLT ? FIX : DONE;
            end
            FIX: begin
                r_next  = {{(WIDTH-1){1'b0}}, set_q};
                state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Published outputs load only on the edge into DONE, so an abort never leaks a partial word
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            a_sr       <= '0;
            b_sr       <= '0;
            r_sr       <= '0;
            op_q       <= '0;
            carry      <= 1'b0;
            set_q      <= 1'b0;
            result_o   <= '0;
            zero_o     <= 1'b0;
            cout_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            state <= state_n;
            r_sr  <= r_next;
            case (state)
                IDLE: if (start_i) begin
                    a_sr  <= src1_i;
                    b_sr  <= src2_i;
                    op_q  <= op_i;
                    idx   <= '0;
                    carry <= cin_init(op_i);
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= co;
                    idx   <= idx + 1'b1;
                    if (last) set_q <= s ^ ov;
                end
                default: ;
            endcase
            if (state_n == DONE) begin
                result_o   <= r_next;
                zero_o     <= r_next == '0;
                cout_o     <= state == RUN && arith && co;
                overflow_o <= state == RUN && arith && ov;
            end
        end
    end
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl: directed vectors plus a cycle-by-cycle arithmetic reference model
module tb_alu_serial_ctrl;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] r;
        logic         z, c, v;
    } res_t;

    logic         clk_i = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [W-1:0] src1 = '0, src2 = '0;
    logic [2:0]   opc = '0;
    logic         ready_o, busy_o, done_o, zero_o, cout_o, overflow_o;
    logic [W-1:0] result_o;

    int tests = 0, fails = 0, cyc = 0;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .start_i(start), .src1_i(src1), .src2_i(src2), .op_i(opc),
        .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
        .zero_o(zero_o), .cout_o(cout_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        res_t x;
        logic [W:0] s;
        x = '0;
        case (op)
            3'b001: x.r = a & b;
            3'b010: x.r = a | b;
            3'b101: x.r = ~(a | b);
            3'b011: begin
                s   = {1'b0, a} + {1'b0, b};
                x.r = s[W-1:0];
                x.c = s[W];
                x.v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            end
            3'b100: begin
                s   = {1'b0, a} + {1'b0, ~b} + 1;
                x.r = s[W-1:0];
                x.c = s[W];
                x.v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
            end
            3'b110: x.r = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
            default: x.r = '0;
        endcase
        x.z = x.r == '0;
        return x;
    endfunction

    bit   m_busy = 0;
    int   m_since = 0, m_lat = 0;
    res_t m_pend = '0, m_held = '0;

    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 0;
            m_since <= 0;
            m_held  <= '0;
        end else if (m_busy) begin
            if (m_since == m_lat) m_busy <= 0;
            m_since <= m_since + 1;
            if (m_since + 1 == m_lat) m_held <= m_pend;
        end else if (start) begin
            m_busy  <= 1;
            m_since <= 0;
            m_pend  <= model(src1, src2, opc);
            m_lat   <= opc == 3'b110 ? W + 1 : W;
        end
    end

    always @(negedge clk_i) begin
        chk("ready", ready_o, !m_busy);
        chk("busy", busy_o, m_busy);
        chk("done", done_o, m_busy && m_since == m_lat);
        chk("result", result_o, m_held.r);
        chk("zero", zero_o, m_held.z);
        chk("cout", cout_o, m_held.c);
        chk("ovf", overflow_o, m_held.v);
    end

    logic [W-1:0] done_q[$];
    int           done_t[$];
    always @(posedge clk_i) cyc <= cyc + 1;
    always @(negedge clk_i) if (done_o) begin
        done_q.push_back(result_o);
        done_t.push_back(cyc);
    end

    task automatic wait_ready();
        int n = 0;
        @(posedge clk_i); #2;
        while (!ready_o && n < 100) begin
            @(posedge clk_i); #2;
            n++;
        end
        chk("ready_timeout", ready_o, 1'b1);
    endtask

    task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                         input logic [W-1:0] er, input logic ez, input logic ec, input logic ev, input int elat);
        int n;
        wait_ready();
        src1 = a; src2 = b; opc = op; start = 1'b1;
        @(posedge clk_i); #2;
        start = 1'b0;
        n = 0;
        @(negedge clk_i);
        while (!done_o && n < 100) begin
            n++;
            @(negedge clk_i);
        end
        chk({nm, "_lat"}, n, elat);
        chk({nm, "_r"}, result_o, er);
        chk({nm, "_z"}, zero_o, ez);
        chk({nm, "_c"}, cout_o, ec);
        chk({nm, "_v"}, overflow_o, ev);
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #2 rst_n = 1'b1;
        chk("rst_result", result_o, 0);
        chk("rst_ready", ready_o, 1);

        do_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 3'b011, 32'h8000_0000, 0, 0, 1, W);
        do_op("sub_eq",  32'h0000_0005, 32'h0000_0005, 3'b100, 32'h0000_0000, 1, 1, 0, W);
        do_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 3'b100, 32'h7FFF_FFFF, 0, 1, 1, W);

        wait_ready();
        src1 = 32'h1234_5678; src2 = 32'h1111_1111; opc = 3'b011; start = 1'b1;
        @(posedge clk_i); #2;
        start = 1'b0;
        repeat (9) @(posedge clk_i);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", ready_o, 1);
        chk("abort_busy", busy_o, 0);
        chk("abort_done", done_o, 0);
        chk("abort_result", result_o, 0);
        chk("abort_zero", zero_o, 0);
        chk("abort_cout", cout_o, 0);
        chk("abort_ovf", overflow_o, 0);
        repeat (2) @(posedge clk_i);
        #2 rst_n = 1'b1;
        do_op("add_3_4", 32'd3, 32'd4, 3'b011, 32'd7, 0, 0, 0, W);

        do_op("slt_m1_1",  32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 32'd1, 0, 0, 0, W + 1);
        do_op("slt_min",   32'h8000_0000, 32'h7FFF_FFFF, 3'b110, 32'd1, 0, 0, 0, W + 1);
        do_op("slt_max",   32'h7FFF_FFFF, 32'h8000_0000, 3'b110, 32'd0, 1, 0, 0, W + 1);
        do_op("slt_equal", 32'h1357_9BDF, 32'h1357_9BDF, 3'b110, 32'd0, 1, 0, 0, W + 1);

        do_op("and", 32'h0F0F_0000, 32'h00F0_000F, 3'b001, 32'h0000_0000, 1, 0, 0, W);
        do_op("or",  32'h0F0F_0000, 32'h00F0_000F, 3'b010, 32'h0FFF_000F, 0, 0, 0, W);
        do_op("nor", 32'h0F0F_0000, 32'h00F0_000F, 3'b101, 32'hF000_FFF0, 0, 0, 0, W);
        do_op("ill", 32'h0F0F_0000, 32'h00F0_000F, 3'b111, 32'h0000_0000, 1, 0, 0, W);

        wait_ready();
        done_q.delete();
        done_t.delete();
        for (int i = 0; i < 110; i++) begin
            src1 = 100 + i; src2 = 2 * i; opc = 3'b011; start = 1'b1;
            @(posedge clk_i); #2;
        end
        start = 1'b0;
        wait_ready();
        chk("b2b_count", done_q.size() >= 3, 1);
        if (done_q.size() >= 3) begin
            chk("b2b_r0", done_q[0], 32'd100);
            chk("b2b_r1", done_q[1], 32'd202);
            chk("b2b_r2", done_q[2], 32'd304);
            chk("b2b_gap", done_t[1] - done_t[0], W + 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
